// File: rtl/fetch_stage.sv
// Instruction fetch stage: 32x68 program memory with PC, MAR, MDR and IR; FETCH_PC_AUTOINC_EN makes IR_wr also step the PC.
// Latency: 4 edges from MAR_wr to IR valid; output mux is combinational. No backpressure: every strobe acts on its edge.
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ProgramCounter_Address_in,
  input  logic        ProgramCounter_wr,
  input  logic        ProgramCounter_rd,
  input  logic        MAR_wr,
  input  logic        MAR_rd,
  input  logic        ProgramMemory_wr,
  input  logic        ProgramMemory_rd,
  input  logic [67:0] Input_instruction,
  input  logic [4:0]  Input_instruction_address,
  input  logic        MDR_wr,
  input  logic        MDR_rd,
  input  logic        IR_wr,
  input  logic        IR_rd,
  output logic [67:0] FetchStage_Output
);

  logic [4:0]  pc_q, pc_d;
  logic [4:0]  mar_q, mar_d;
  logic [4:0]  rd_addr;
  logic [67:0] pm_q, pm_d;
  logic [67:0] mdr_q, mdr_d;
  logic [67:0] ir_q, ir_d;
  logic [67:0] mem [32];
  logic        pc_inc;

`ifdef FETCH_PC_AUTOINC_EN
  assign pc_inc = ProgramCounter_rd | IR_wr;
`else
  assign pc_inc = ProgramCounter_rd;
`endif

  assign rd_addr = MAR_rd ? mar_q : Input_instruction_address;

  always_comb begin
    pc_d = pc_q;
    if (ProgramCounter_wr) begin
      pc_d = ProgramCounter_Address_in;
    end else if (pc_inc) begin
      pc_d = pc_q + 5'd1;
    end
  end

  always_comb begin
    mar_d = MAR_wr ? pc_q : mar_q;
    pm_d  = ProgramMemory_rd ? mem[rd_addr] : pm_q;
    mdr_d = MDR_wr ? pm_q : mdr_q;
    ir_d  = IR_wr ? mdr_q : ir_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      mar_q <= '0;
      pm_q  <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      pm_q  <= pm_d;
      mdr_q <= mdr_d;
      ir_q  <= ir_d;
    end
  end

  // Storage is never reset; the read above samples the pre-edge contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst_n && ProgramMemory_wr) begin
      mem[Input_instruction_address] <= Input_instruction;
    end
  end

  always_comb begin
    if (IR_rd) begin
      FetchStage_Output = ir_q;
    end else if (MDR_rd) begin
      FetchStage_Output = mdr_q;
    end else begin
      FetchStage_Output = pm_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; define FETCH_PC_AUTOINC_EN to also cover the auto-increment build.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  pc_in;
  logic        pc_wr, pc_rd, mar_wr, mar_rd, pm_wr, pm_rd, mdr_wr, mdr_rd, ir_wr, ir_rd;
  logic [67:0] instr;
  logic [4:0]  iaddr;
  logic [67:0] out;

  int n_vec = 0;
  int n_err = 0;

  logic [67:0] prog [7];

  fetch_stage dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .ProgramCounter_Address_in (pc_in),
    .ProgramCounter_wr         (pc_wr),
    .ProgramCounter_rd         (pc_rd),
    .MAR_wr                    (mar_wr),
    .MAR_rd                    (mar_rd),
    .ProgramMemory_wr          (pm_wr),
    .ProgramMemory_rd          (pm_rd),
    .Input_instruction         (instr),
    .Input_instruction_address (iaddr),
    .MDR_wr                    (mdr_wr),
    .MDR_rd                    (mdr_rd),
    .IR_wr                     (ir_wr),
    .IR_rd                     (ir_rd),
    .FetchStage_Output         (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pc_wr = 0; pc_rd = 0; mar_wr = 0; mar_rd = 0; pm_wr = 0; pm_rd = 0;
    mdr_wr = 0; mdr_rd = 0; ir_wr = 0; ir_rd = 0;
  endtask

  task automatic pm_write(input logic [4:0] a, input logic [67:0] d);
    clr(); pm_wr = 1; iaddr = a; instr = d; tick(); clr();
  endtask

  task automatic pm_direct_read(input logic [4:0] a);
    clr(); pm_rd = 1; iaddr = a; tick(); clr();
  endtask

  // MAR <= PC, then read memory through MAR into pm_q.
  task automatic mar_read();
    clr(); mar_wr = 1; tick();
    clr(); mar_rd = 1; pm_rd = 1; tick(); clr();
  endtask

  task automatic full_fetch();
    mar_read();
    mdr_wr = 1; tick(); clr();
    ir_wr = 1; tick(); clr();
  endtask

  initial begin
    prog[0] = 68'h9_00000000_00000003;
    prog[1] = 68'hD_0000000B_00000004;
    prog[2] = 68'h0_00000000_0000000B;
    prog[3] = 68'hB_00000000_00000005;
    prog[4] = 68'h0;
    prog[5] = 68'hA_55555555_00000005;
    prog[6] = 68'h6_66666666_00000006;

    clr(); pc_in = 0; instr = 0; iaddr = 0;
    rst_n = 0;
    tick();
    chk("reset_out", out, 68'h0);
    ir_rd = 1; #1;
    chk("reset_ir", out, 68'h0);
    clr();
    rst_n = 1;
    tick();

    for (int i = 0; i < 7; i++) pm_write(i[4:0], prog[i]);

    for (int i = 0; i < 4; i++) begin
      pm_direct_read(i[4:0]);
      chk($sformatf("readback%0d", i), out, prog[i]);
    end

    // Full fetch from PC=1.
    pc_wr = 1; pc_in = 5'd1; tick(); clr();
    mar_read();
    chk("fetch_pm", out, prog[1]);
    mdr_wr = 1; tick(); clr();
    mdr_rd = 1; #1;
    chk("fetch_mdr", out, prog[1]);
    clr();
    ir_wr = 1; tick(); clr();
    ir_rd = 1; #1;
    chk("fetch_ir", out, 68'hD_0000000B_00000004);
    clr();

    // Output priority: IR=prog1, MDR=prog0, pm_q=prog2.
    pm_direct_read(5'd0);
    mdr_wr = 1; tick(); clr();
    pm_direct_read(5'd2);
    ir_rd = 1; mdr_rd = 1; #1;
    chk("mux_ir_over_mdr", out, prog[1]);
    ir_rd = 0; #1;
    chk("mux_mdr", out, prog[0]);
    mdr_rd = 0; #1;
    chk("mux_pm", out, prog[2]);

    // PC wrap 31 -> 0.
    clr(); pc_wr = 1; pc_in = 5'd31; tick(); clr();
    pc_rd = 1; tick(); clr();
    mar_read();
    chk("pc_wrap", out, prog[0]);

    // MAR captures pre-edge PC while PC increments (PC 0 -> 1).
    mar_wr = 1; pc_rd = 1; tick(); clr();
    mar_rd = 1; pm_rd = 1; tick(); clr();
    chk("mar_pre_edge", out, prog[0]);
    mar_read();
    chk("pc_after_inc", out, prog[1]);

    // Write beats increment.
    pc_wr = 1; pc_rd = 1; pc_in = 5'd5; tick(); clr();
    mar_read();
    chk("pc_wr_priority", out, prog[5]);

    // Read-before-write on address 2.
    pm_wr = 1; pm_rd = 1; iaddr = 5'd2; instr = 68'h1; tick(); clr();
    chk("rbw_old", out, 68'h0_00000000_0000000B);
    pm_direct_read(5'd2);
    chk("rbw_new", out, 68'h1);

    // Reset mid-fetch, with a suppressed write attempt during reset.
    pc_wr = 1; pc_in = 5'd1; tick(); clr();
    mar_read();
    mdr_wr = 1; tick(); clr();
    ir_wr = 1; mar_wr = 1; #2;
    rst_n = 0; #1;
    clr(); ir_rd = 1; #1;
    chk("rst_mid_ir", out, 68'h0);
    ir_rd = 0; mdr_rd = 1; #1;
    chk("rst_mid_mdr", out, 68'h0);
    clr(); pm_wr = 1; iaddr = 5'd3; instr = 68'hF_FFFFFFFF_FFFFFFFF; tick(); clr();
    rst_n = 1;
    tick();
    ir_rd = 1; #1;
    chk("post_rst_ir", out, 68'h0);
    clr();
    pm_direct_read(5'd3);
    chk("mem_wr_suppressed", out, prog[3]);
    pm_direct_read(5'd0);
    chk("mem_retained", out, prog[0]);

`ifdef FETCH_PC_AUTOINC_EN
    clr(); pc_wr = 1; pc_in = 5'd0; tick(); clr();
    full_fetch();
    ir_rd = 1; #1;
    chk("autoinc_fetch0", out, prog[0]);
    clr();
    full_fetch();
    ir_rd = 1; #1;
    chk("autoinc_fetch1", out, prog[1]);
    clr();
`else
    // Without auto-increment, back-to-back fetches from PC=0 stay at address 0.
    clr(); pc_wr = 1; pc_in = 5'd0; tick(); clr();
    full_fetch();
    full_fetch();
    ir_rd = 1; #1;
    chk("no_autoinc", out, prog[0]);
    clr();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined processor: a 32-entry × 68-bit program memory plus the PC, MAR, MDR and IR registers that move one instruction from memory to the decode stage. Each register is controlled by an explicit read/write strobe pair driven by the control unit. The program memory is loaded through a dedicated write port before execution. The stage presents the selected 68-bit instruction on `FetchStage_Output`.

## Interface

Parameters: none. Widths are fixed: 68-bit instruction, 5-bit address, 32 memory entries.

Instruction format: [67:65] opcode (000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 LDA, 101 STA, 110 MOV), [64] mode (1 address, 0 data), [63:32] operand A / register code (0xB = B, 0xC = C), [31:0] operand B.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ProgramCounter_Address_in  in  5  PC load value.
- ProgramCounter_wr  in  1  load PC.
- ProgramCounter_rd  in  1  increment PC.
- MAR_wr  in  1  MAR <= PC.
- MAR_rd  in  1  MAR drives the memory read address.
- ProgramMemory_wr  in  1  memory write enable.
- ProgramMemory_rd  in  1  memory read enable.
- Input_instruction  in  68  memory write data.
- Input_instruction_address  in  5  memory write address; also the read address when MAR_rd=0.
- MDR_wr  in  1  MDR <= memory read data.
- MDR_rd  in  1  select MDR onto the output.
- IR_wr  in  1  IR <= MDR.
- IR_rd  in  1  select IR onto the output.
- FetchStage_Output  out  68  fetched instruction.

## Operation

- **PC** (5 bit)
  - ProgramCounter_wr: PC <= ProgramCounter_Address_in.
  - Else ProgramCounter_rd: PC <= PC+1, wrapping 31→0.
  - Write has priority over increment.
- **MAR** (5 bit): MAR_wr: MAR <= PC. Captures the pre-edge PC when PC changes on the same edge.
- **Memory read address**: MAR_rd ? MAR : Input_instruction_address.
- **Memory write**: ProgramMemory_wr: mem[Input_instruction_address] <= Input_instruction.
- **Memory read**
  - ProgramMemory_rd: pm_q <= mem[read address]; otherwise pm_q holds.
  - Simultaneous read and write to the same address returns the old data (read-before-write).
- **MDR** (68 bit): MDR_wr: MDR <= pm_q.
- **IR** (68 bit): IR_wr: IR <= MDR.
- **Output** (combinational): IR_rd ? IR : MDR_rd ? MDR : pm_q. IR_rd has priority over MDR_rd.
- **Reset**
  - rst_n low immediately clears PC, MAR, pm_q, MDR and IR to 0, so FetchStage_Output = 0.
  - Memory contents are not cleared and are retained across reset.
  - Memory writes are suppressed while rst_n is low.
  - Reset asserted mid-fetch aborts the fetch; no partial update survives.

## Timing

- All register and memory updates occur on the rising edge of clk; the output mux is combinational.
- A memory write is visible to a read issued on the next edge.
- Canonical fetch, one edge per step:
  - E1: MAR_wr (optionally with ProgramCounter_rd).
  - E2: MAR_rd + ProgramMemory_rd.
  - E3: MDR_wr.
  - E4: IR_wr.
  - IR_rd then presents the instruction. Latency from MAR_wr to IR valid: 4 edges.
- Strobes may overlap; each register samples its own inputs independently at each edge.

## Configuration

- FETCH_PC_AUTOINC_EN defined: an IR_wr edge also increments PC (wrap 31→0), unless ProgramCounter_wr is asserted on that edge. ProgramCounter_rd on the same edge still produces a single +1.
- Not defined: PC changes only via ProgramCounter_wr / ProgramCounter_rd.

## Test plan

- **Reset**: rst_n=0 mid-operation → FetchStage_Output=0 with IR_rd=1 or MDR_rd=1. Memory data written earlier is still readable after reset.
- **Load / readback**
  - Stimulus: write addresses 0–4 with 68'h9_00000000_00000003, 68'hD_0000000B_00000004, 68'h0_00000000_0000000B, 68'hB_00000000_00000005, 0. Then ProgramMemory_rd=1, MAR_rd=0, address sweeping 0..3.
  - Required: output (no IR_rd/MDR_rd) shows each value one edge after its address.
- **Full fetch**: ProgramCounter_wr with 1, then the E1–E4 sequence, then IR_rd=1 → FetchStage_Output=68'hD_0000000B_00000004.
- **PC wrap / priority**: load 31, ProgramCounter_rd → PC=0. ProgramCounter_wr=1 and ProgramCounter_rd=1 with input 5 → PC=5.
- **Read-before-write**: ProgramMemory_wr and ProgramMemory_rd on address 2 with new data 68'h1 → pm_q=68'h0_00000000_0000000B; the next read returns 68'h1.
- **Macro**: with FETCH_PC_AUTOINC_EN, two consecutive fetches starting at PC=0 → IR holds the addr 0 instruction, then the addr 1 instruction, with no ProgramCounter_rd.
